spi_master_arbiter: RTL and testbench
=====================================

Name: spi_master_arbiter

Overview:
- Shares one spi_master byte engine between NUM_REQ requesters. Each requester targets its own slave.
- Grants round-robin, one burst per grant. The grant is locked until the requester's last byte.
- Owns the per-slave select lines, so chip select stays low across a multi-byte burst.
- Drives spi_master start/tx_data, watches its done/rx_data, and returns each received byte to the owning requester.

Parameters:
- NUM_REQ, 4, number of requesters and slave selects (2..8).
- GAP_CYCLES, 4, clk cycles with all selects high between bursts (>=1).
- HOLD_TIMEOUT, 1024, max clk cycles the owner may stall mid-burst before abort; 0 disables abort.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, synchronous, active-low.
- req  in  NUM_REQ  per-requester byte request; held with data until req_ack.
- req_last  in  NUM_REQ  qualifies req: this byte ends the burst.
- req_data  in  8*NUM_REQ  tx byte; requester i uses bits [8i+7:8i].
- req_ack  out  NUM_REQ  1-cycle pulse: byte accepted.
- rsp_valid  out  NUM_REQ  1-cycle pulse: rsp_data holds this requester's rx byte.
- rsp_data  out  8  shared rx byte.
- abort  out  NUM_REQ  1-cycle pulse: owner's burst killed by timeout.
- ss_n  out  NUM_REQ  active-low slave selects, at most one low.
- busy  out  1  high in every state except IDLE.
- m_start  out  1  to spi_master start; 1-cycle pulse.
- m_tx_data  out  8  to spi_master tx_data.
- m_rx_data  in  8  from spi_master rx_data.
- m_done  in  1  from spi_master done; level or pulse accepted.

Behaviour:
- Reset, synchronous on clk when rst_n=0:
  - state IDLE, rr pointer 0, all counters 0.
  - req_ack/rsp_valid/abort/m_start = 0; rsp_data, m_tx_data = 0; ss_n all 1; busy 0.
  - Reset mid-burst releases ss_n the next edge, with no rsp or abort pulse.
- All outputs are registered.
- m_done is edge-detected with a registered copy. Only a 0->1 edge seen in WAIT counts, so a done level left over from a previous byte is ignored.
- IDLE:
  - If any req, pick the first set bit searching from rr_ptr upward with wrap; that requester becomes owner.
  - Drive ss_n[owner]=0 and go to ISSUE. No req: stay.
- ISSUE, one cycle:
  - m_start=1, m_tx_data=req_data[owner], req_ack[owner]=1.
  - Latch last_q=req_last[owner]; go to WAIT.
  - Latency from req in IDLE to m_start is 2 cycles.
- WAIT:
  - On m_done rising edge: rsp_data<=m_rx_data and rsp_valid[owner]=1 next cycle.
  - Then: if last_q, go to GAP. Else if req[owner], go to ISSUE. Else go to HOLD.
  - No timeout applies in WAIT.
- HOLD:
  - ss_n[owner] stays 0 and a stall counter increments.
  - On req[owner], clear the counter and go to ISSUE.
  - If the counter reaches HOLD_TIMEOUT (nonzero), pulse abort[owner] and go to GAP.
  - req from other requesters is ignored while a burst is owned.
- GAP:
  - ss_n all 1, count GAP_CYCLES, then IDLE.
  - On entry, rr_ptr <= owner+1 mod NUM_REQ.
- Boundary cases:
  - Single-byte burst (req_last on the first byte) is legal.
  - Simultaneous requests: lowest index at or after rr_ptr wins; others wait. No requester starves: worst case NUM_REQ-1 bursts ahead.
  - If the owner asserts req and the stall counter hits HOLD_TIMEOUT in the same HOLD cycle, req wins.
  - req_last without req is ignored.

Decomposition:
- Package spi_arb_pkg holds:
  - the state enum (IDLE, ISSUE, WAIT, HOLD, GAP);
  - the localparam SPI_BYTE_W=8;
  - the function clog2 for the owner/pointer width.
- Sub-module rr_picker(NUM_REQ): combinational one-hot/index grant from req and rr_ptr. It is reused by later bus arbiters.

Test Plan:
- Single requester, NUM_REQ=4: req[0] with 0xA5, last=1, slave returns 0x3C.
  - Expect ss_n=4'b1110, one m_start with m_tx_data=0xA5, rsp_valid[0] with rsp_data=0x3C, then ss_n=4'hF for 4 cycles.
- Burst: req[2] sends 0x11, 0x22, 0x33 (last on 0x33).
  - Expect ss_n[2] low continuously across all three bytes, 3 req_ack and 3 rsp_valid pulses on index 2.
- Contention: req[1] and req[3] asserted together from reset (rr_ptr=0).
  - Expect 1 served, then 3. Then with req[1] and req[3] both asserted again, expect 3 served before 1.
- Stall/timeout with HOLD_TIMEOUT=16: req[0] non-last byte, then req dropped.
  - Expect ss_n[0] low for 16 cycles after rsp, abort[0] pulse, selects released, then req[1] granted.
- Stale done: hold m_done high from a prior byte when ISSUE occurs.
  - Expect no rsp_valid until m_done falls and rises again.
- Reset mid-burst: rst_n=0 during WAIT.
  - Expect ss_n=all 1, busy=0, no pulses on the next edge.

Source files
------------

// File: rtl/spi_master_arbiter_pkg.sv
// spi_arb_pkg: shared types, widths and helpers for the SPI master arbiter.
package spi_arb_pkg;
  localparam int SPI_BYTE_W = 8;
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, HOLD, GAP} state_e;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/spi_master_arbiter_if.sv
// spi_master_arbiter_if: requester bus plus spi_master engine connection.
interface spi_master_arbiter_if
  import spi_arb_pkg::*;
#(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0] req, req_last, req_ack, rsp_valid, abort, ss_n;
  logic [NUM_REQ*SPI_BYTE_W-1:0] req_data;
  logic [SPI_BYTE_W-1:0] rsp_data, m_tx_data, m_rx_data;
  logic busy, m_start, m_done;
  modport master (
    input req, req_last, req_data, m_rx_data, m_done,
    output req_ack, rsp_valid, rsp_data, abort, ss_n, busy, m_start, m_tx_data
  );
  modport slave (
    output req, req_last, req_data, m_rx_data, m_done,
    input req_ack, rsp_valid, rsp_data, abort, ss_n, busy, m_start, m_tx_data
  );
endinterface

// File: rtl/spi_master_arbiter_rr_picker.sv
// rr_picker: combinational round-robin pick, first set req at or after ptr with wrap.
module rr_picker
  import spi_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  localparam int IW = clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic               valid,
  output logic [IW-1:0]      idx,
  output logic [NUM_REQ-1:0] grant
);
  always_comb begin
    valid = 1'b0;
    idx = ptr;
    // walk from the far end so the nearest candidate to ptr is written last
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req[IW'((int'(ptr) + k) % NUM_REQ)]) begin
        valid = 1'b1;
        idx = IW'((int'(ptr) + k) % NUM_REQ);
      end
    end
    grant = valid ? NUM_REQ'(1) << idx : '0;
  end
endmodule

// File: rtl/spi_master_arbiter.sv
// spi_master_arbiter: round-robin sharing of one SPI byte engine, burst-locked grants with per-slave selects.
module spi_master_arbiter
  import spi_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int GAP_CYCLES = 4,
  parameter int HOLD_TIMEOUT = 1024
) (
  input logic clk,
  input logic rst_n,
  spi_master_arbiter_if.master bus
);
  localparam int IW = clog2(NUM_REQ);
  localparam int HW = clog2(HOLD_TIMEOUT + 2);
  localparam int GW = clog2(GAP_CYCLES + 1);
  state_e state, state_d;
  logic [IW-1:0] owner, owner_d, rr_ptr, rr_d, pick_idx;
  logic [NUM_REQ-1:0] pick_g, own_oh, ss_d, ack_d, rsp_d, abort_d;
  logic [HW-1:0] hcnt, hcnt_d;
  logic [GW-1:0] gcnt, gcnt_d;
  logic [SPI_BYTE_W-1:0] tx_d, rdata_d;
  logic pick_v, last_q, last_d, done_q, start_d, to_gap;
  rr_picker #(.NUM_REQ(NUM_REQ)) u_pick (
    .req(bus.req), .ptr(rr_ptr), .valid(pick_v), .idx(pick_idx), .grant(pick_g)
  );
  assign own_oh = NUM_REQ'(1) << owner;
  always_comb begin
    state_d = state;
    owner_d = owner;
    rr_d = rr_ptr;
    last_d = last_q;
    hcnt_d = hcnt;
    gcnt_d = gcnt;
    ss_d = bus.ss_n;
    tx_d = bus.m_tx_data;
    rdata_d = bus.rsp_data;
    ack_d = '0;
    rsp_d = '0;
    abort_d = '0;
    start_d = 1'b0;
    to_gap = 1'b0;
    case (state)
      IDLE: if (pick_v) begin
        owner_d = pick_idx;
        ss_d = ~pick_g;
        state_d = ISSUE;
      end
      ISSUE: begin
        start_d = 1'b1;
        tx_d = bus.req_data[int'(owner)*SPI_BYTE_W +: SPI_BYTE_W];
        ack_d = own_oh;
        last_d = bus.req_last[owner];
        state_d = WAIT;
      end
      // only a fresh rising edge of done completes the byte
      WAIT: if (bus.m_done && !done_q) begin
        rdata_d = bus.m_rx_data;
        rsp_d = own_oh;
        hcnt_d = '0;
        to_gap = last_q;
        state_d = last_q ? GAP : bus.req[owner] ? ISSUE : HOLD;
      end
      HOLD: begin
        hcnt_d = hcnt + 1'b1;
        if (bus.req[owner]) begin
          hcnt_d = '0;
          state_d = ISSUE;
        end else if (HOLD_TIMEOUT != 0 && hcnt_d == HW'(HOLD_TIMEOUT)) begin
          abort_d = own_oh;
          to_gap = 1'b1;
        end
      end
      GAP: begin
        gcnt_d = gcnt + 1'b1;
        state_d = gcnt == GW'(GAP_CYCLES - 1) ? IDLE : GAP;
      end
      default: state_d = IDLE;
    endcase
    if (to_gap) begin
      state_d = GAP;
      ss_d = '1;
      gcnt_d = '0;
      hcnt_d = '0;
      rr_d = owner == IW'(NUM_REQ - 1) ? '0 : owner + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      owner <= '0;
      rr_ptr <= '0;
      last_q <= 1'b0;
      hcnt <= '0;
      gcnt <= '0;
      done_q <= 1'b0;
      bus.req_ack <= '0;
      bus.rsp_valid <= '0;
      bus.abort <= '0;
      bus.m_start <= 1'b0;
      bus.rsp_data <= '0;
      bus.m_tx_data <= '0;
      bus.ss_n <= '1;
      bus.busy <= 1'b0;
    end else begin
      state <= state_d;
      owner <= owner_d;
      rr_ptr <= rr_d;
      last_q <= last_d;
      hcnt <= hcnt_d;
      gcnt <= gcnt_d;
      done_q <= bus.m_done;
      bus.req_ack <= ack_d;
      bus.rsp_valid <= rsp_d;
      bus.abort <= abort_d;
      bus.m_start <= start_d;
      bus.rsp_data <= rdata_d;
      bus.m_tx_data <= tx_d;
      bus.ss_n <= ss_d;
      bus.busy <= state_d != IDLE;
    end
  end
endmodule

// File: tb/tb_spi_master_arbiter.sv
// tb_spi_master_arbiter: directed checks of grant order, burst select hold, timeout, stale done and reset.
module tb_spi_master_arbiter;
  logic clk, rst_n;
  spi_master_arbiter_if #(.NUM_REQ(4)) bus ();
  spi_master_arbiter #(.NUM_REQ(4), .GAP_CYCLES(4), .HOLD_TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  logic auto_slave = 1'b1, s_done = 1'b0, man_done = 1'b0;
  logic [7:0] s_tx, s_rx = 8'h00, man_rx = 8'h00;
  assign bus.m_done = s_done | man_done;
  assign bus.m_rx_data = auto_slave ? s_rx : man_rx;
  // slave engine: answers each start with tx^0x99 after a few cycles
  always begin
    @(posedge clk);
    if (auto_slave && bus.m_start) begin
      s_tx = bus.m_tx_data;
      repeat (3) @(posedge clk);
      #1 s_rx = s_tx ^ 8'h99;
      s_done = 1'b1;
      @(posedge clk);
      #1 s_done = 1'b0;
    end
  end
  int n_checks = 0, n_fail = 0;
  int ack_n[4] = '{default: 0};
  int rsp_n[4] = '{default: 0};
  int abort_n[4] = '{default: 0};
  int start_n = 0, breaks2 = 0, multi_low = 0;
  logic watch2 = 1'b0;
  logic [3:0] prev_ss = 4'hF;
  logic [7:0] rsp_log[$];
  int grant_q[$];
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      ack_n[i] += int'(bus.req_ack[i]);
      rsp_n[i] += int'(bus.rsp_valid[i]);
      abort_n[i] += int'(bus.abort[i]);
      if (bus.req_ack[i] && bus.req_last[i]) bus.req[i] = 1'b0;
    end
    start_n += int'(bus.m_start);
    if (bus.rsp_valid != 0) rsp_log.push_back(bus.rsp_data);
    if (watch2 && bus.ss_n[2] && rsp_n[2] < 3) breaks2++;
    if ($countones(~bus.ss_n) > 1) multi_low++;
    if (prev_ss == 4'hF && bus.ss_n != 4'hF)
      for (int i = 0; i < 4; i++) if (!bus.ss_n[i]) grant_q.push_back(i);
    prev_ss = bus.ss_n;
  endtask
  task automatic wait_ack(input int i);
    int n = 0;
    do begin tick(); n++; end while (!bus.req_ack[i] && n < 60);
    check("ack_wait", bus.req_ack[i], 1);
  endtask
  task automatic wait_rsp(input int i);
    int n = 0;
    do begin tick(); n++; end while (!bus.rsp_valid[i] && n < 60);
    check("rsp_wait", bus.rsp_valid[i], 1);
  endtask
  task automatic wait_idle();
    int n = 0;
    do begin tick(); n++; end while (bus.busy && n < 200);
    check("idle_wait", bus.busy, 0);
  endtask
  task automatic put(input int i, input logic [7:0] d, input logic last);
    bus.req_data[i*8 +: 8] = d;
    bus.req_last[i] = last;
    bus.req[i] = 1'b1;
  endtask
  initial begin
    int g, h, a1, r3;
    logic re;
    rst_n = 1'b0;
    bus.req = '0;
    bus.req_last = '0;
    bus.req_data = '0;
    repeat (3) tick();
    check("rst_ss_n", bus.ss_n, 4'hF);
    check("rst_busy", bus.busy, 0);
    check("rst_pulses", {bus.req_ack, bus.rsp_valid, bus.abort, bus.m_start}, 0);
    check("rst_data", {bus.rsp_data, bus.m_tx_data}, 0);
    rst_n = 1'b1;
    tick();
    // single byte to requester 0
    put(0, 8'hA5, 1'b1);
    tick();
    check("t1_select", bus.ss_n, 4'hE);
    check("t1_no_start_yet", bus.m_start, 0);
    tick();
    check("t1_start", bus.m_start, 1);
    check("t1_tx", bus.m_tx_data, 8'hA5);
    check("t1_ack", bus.req_ack, 4'b0001);
    wait_rsp(0);
    check("t1_rx", bus.rsp_data, 8'h3C);
    check("t1_release", bus.ss_n, 4'hF);
    check("t1_one_start", start_n, 1);
    // next burst waits out the gap: 4 GAP cycles plus the IDLE pick cycle
    rsp_log.delete();
    put(2, 8'h11, 1'b0);
    g = 1;
    tick();
    while (bus.ss_n == 4'hF && g < 40) begin g++; tick(); end
    check("t1_gap_len", g, 5);
    check("t2_select", bus.ss_n, 4'hB);
    wait_ack(2);
    watch2 = 1'b1;
    put(2, 8'h22, 1'b0);
    wait_ack(2);
    put(2, 8'h33, 1'b1);
    wait_ack(2);
    wait_idle();
    watch2 = 1'b0;
    check("t2_acks", ack_n[2], 3);
    check("t2_rsps", rsp_n[2], 3);
    check("t2_ss_held", breaks2, 0);
    check("t2_rx0", rsp_log[0], 8'h88);
    check("t2_rx1", rsp_log[1], 8'hBB);
    check("t2_rx2", rsp_log[2], 8'hAA);
    // contention from reset, requester 1 re-requests right after its ack
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    grant_q.delete();
    put(1, 8'h41, 1'b1);
    put(3, 8'h43, 1'b1);
    a1 = ack_n[1];
    re = 1'b0;
    for (int n = 0; n < 300; n++) begin
      tick();
      if (!re && ack_n[1] == a1 + 1) begin bus.req[1] = 1'b1; re = 1'b1; end
      if (re && bus.req == 0 && !bus.busy) break;
    end
    check("t3_grants", grant_q.size(), 3);
    check("t3_first", grant_q[0], 1);
    check("t3_second", grant_q[1], 3);
    check("t3_third", grant_q[2], 1);
    // stall then timeout on requester 0, requester 1 waiting
    grant_q.delete();
    put(0, 8'h5A, 1'b0);
    wait_ack(0);
    bus.req[0] = 1'b0;
    a1 = ack_n[1];
    put(1, 8'h66, 1'b1);
    wait_rsp(0);
    check("t4_rx", bus.rsp_data, 8'hC3);
    h = 0;
    while (!bus.ss_n[0] && h < 100) begin h++; tick(); end
    check("t4_hold_len", h, 16);
    check("t4_abort", bus.abort, 4'b0001);
    check("t4_other_ignored", ack_n[1], a1);
    wait_ack(1);
    check("t4_grant_after", grant_q.size() == 2 ? grant_q[1] : -1, 1);
    check("t4_abort_once", abort_n[0], 1);
    wait_idle();
    // stale done level must not complete the byte
    auto_slave = 1'b0;
    man_done = 1'b1;
    r3 = rsp_n[3];
    put(3, 8'h77, 1'b1);
    wait_ack(3);
    repeat (6) tick();
    check("t5_stale_high", rsp_n[3], r3);
    man_done = 1'b0;
    repeat (2) tick();
    check("t5_stale_low", rsp_n[3], r3);
    man_rx = 8'h5E;
    man_done = 1'b1;
    tick();
    check("t5_rsp", bus.rsp_valid, 4'b1000);
    check("t5_rx", bus.rsp_data, 8'h5E);
    man_done = 1'b0;
    wait_idle();
    auto_slave = 1'b1;
    // reset while waiting on the engine
    put(2, 8'h10, 1'b0);
    wait_ack(2);
    check("t6_owned", bus.ss_n, 4'hB);
    rst_n = 1'b0;
    bus.req[2] = 1'b0;
    tick();
    check("t6_ss_n", bus.ss_n, 4'hF);
    check("t6_busy", bus.busy, 0);
    check("t6_pulses", {bus.req_ack, bus.rsp_valid, bus.abort, bus.m_start}, 0);
    rst_n = 1'b1;
    a1 = rsp_n[2];
    repeat (8) tick();
    check("t6_no_late_rsp", rsp_n[2], a1);
    check("one_hot_select", multi_low, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
